// File: rtl/mem_access_ctrl.sv
// Asynchronous SRAM access sequencer: turns level read/write requests into
// registered CE/OE/WE strobe sequences with a programmable access length.
module mem_access_ctrl #(
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Req_Read,
    input  logic        Req_Write,
    input  logic [15:0] Addr,
    input  logic [15:0] Wdata,
    output logic [15:0] Rdata,
    output logic        Busy,
    output logic        Done,
    output logic [19:0] Mem_ADDR,
    output logic        Mem_CE,
    output logic        Mem_UB,
    output logic        Mem_LB,
    output logic        Mem_OE,
    output logic        Mem_WE,
    output logic [15:0] Mem_Data_Out,
    output logic        Mem_Data_Drive,
    input  logic [15:0] Mem_Data_In
);

    typedef enum logic [2:0] {
        IDLE, RD_ACCESS, WR_SETUP, WR_PULSE, WR_HOLD, DONE
    } state_t;

    localparam logic [2:0] WAIT_LD = 3'(WAIT_CYCLES);

    state_t      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [15:0] addr_q, addr_d;
    logic [15:0] wdata_q, wdata_d;
    logic [15:0] rdata_q, rdata_d;
    logic        ce_q, ce_d;
    logic        oe_q, oe_d;
    logic        we_q, we_d;
    logic        drive_q, drive_d;
    logic [15:0] dout_q, dout_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        case (state_q)
            IDLE: begin
                // Read wins when both requests are present; the write is dropped.
                if (Req_Read) begin
                    addr_d  = Addr;
                    cnt_d   = WAIT_LD;
                    state_d = RD_ACCESS;
                end else if (Req_Write) begin
                    addr_d  = Addr;
                    wdata_d = Wdata;
                    cnt_d   = WAIT_LD;
                    state_d = WR_SETUP;
                end
            end
            RD_ACCESS: begin
                if (cnt_q == 3'd0) begin
                    rdata_d = Mem_Data_In;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            WR_SETUP: begin
                cnt_d   = WAIT_LD;
                state_d = WR_PULSE;
            end
            WR_PULSE: begin
                if (cnt_q == 3'd0) state_d = WR_HOLD;
                else               cnt_d   = cnt_q - 3'd1;
            end
            WR_HOLD: state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Strobes are decoded from the next state so every output comes straight off a flop.
        ce_d    = !(state_d inside {RD_ACCESS, WR_SETUP, WR_PULSE, WR_HOLD});
        oe_d    = (state_d != RD_ACCESS);
        we_d    = (state_d != WR_PULSE);
        drive_d = (state_d inside {WR_SETUP, WR_PULSE, WR_HOLD});
        dout_d  = drive_d ? wdata_d : 16'h0000;
        busy_d  = (state_d != IDLE);
        done_d  = (state_d == DONE);
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q <= IDLE;
            cnt_q   <= 3'd0;
            addr_q  <= 16'h0000;
            wdata_q <= 16'h0000;
            rdata_q <= 16'h0000;
            ce_q    <= 1'b1;
            oe_q    <= 1'b1;
            we_q    <= 1'b1;
            drive_q <= 1'b0;
            dout_q  <= 16'h0000;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            ce_q    <= ce_d;
            oe_q    <= oe_d;
            we_q    <= we_d;
            drive_q <= drive_d;
            dout_q  <= dout_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign Rdata          = rdata_q;
    assign Busy           = busy_q;
    assign Done           = done_q;
    assign Mem_ADDR       = {4'b0000, addr_q};
    assign Mem_CE         = ce_q;
    assign Mem_UB         = ce_q;
    assign Mem_LB         = ce_q;
    assign Mem_OE         = oe_q;
    assign Mem_WE         = we_q;
    assign Mem_Data_Out   = dout_q;
    assign Mem_Data_Drive = drive_q;

endmodule
